grf_multiport: RTL and testbench

GRF_MULTIPORT -- requirements
Module: grf_multiport

---
 rtl/grf_multiport_if.sv | 40 ++++
 rtl/grf_multiport.sv | 113 +++++++++++
 tb/tb_grf_multiport.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_multiport_if.sv
// grf_multiport_if: read, write and issue signals of the multiport general register file.
// The master drives the read addresses, write ports and producer issue.
// The slave (the register file) returns read data, pending flags and the pending count.
//
// Port semantics: there is no handshake on these ports.
// - A write is a one-cycle pulse: we0/we1 high with wa/wd valid commits at that rising edge.
// - An issue is a one-cycle pulse: iss_we high with iss_addr valid marks the register pending at that edge.
// - Reads are address-in / data-out in the same cycle.
interface grf_multiport_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [AW-1:0] ra1, ra2, ra3;
  logic [DW-1:0] rd1, rd2, rd3;
  logic          rbusy1, rbusy2, rbusy3;
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [DW-1:0] wd0, wd1;
  logic          iss_we;
  logic [AW-1:0] iss_addr;
  logic [AW:0]   busy_cnt;

  modport master (
    output ra1, ra2, ra3,
    output we0, we1, wa0, wa1, wd0, wd1,
    output iss_we, iss_addr,
    input  rd1, rd2, rd3,
    input  rbusy1, rbusy2, rbusy3,
    input  busy_cnt
  );

  modport slave (
    input  ra1, ra2, ra3,
    input  we0, we1, wa0, wa1, wd0, wd1,
    input  iss_we, iss_addr,
    output rd1, rd2, rd3,
    output rbusy1, rbusy2, rbusy3,
    output busy_cnt
  );
endinterface

// File: rtl/grf_multiport.sv
// grf_multiport: 3-read / 2-write register file with a pending (busy) scoreboard.
// - Register 0 is hardwired to zero and is never marked pending.
// - When both write ports target the same address, write port 1 (the younger instruction) wins.
// - busy_cnt is a registered popcount of the busy vector.
// Optional feature: define GRF_MULTIPORT_BYPASS_EN to enable same-cycle write-through forwarding
// on the read ports, including the matching rbusy override.
module grf_multiport #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic            clk,
  input  logic            reset,
  grf_multiport_if.slave  bus
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = AW + 1;

  logic [DW-1:0]          regs [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic [DEPTH-1:0]       busy_nxt;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_nxt;

  logic                   commit0;
  logic                   commit1;
  logic                   commit0_eff;
  logic                   iss_set;

  logic [2:0][AW-1:0]     ra;
  logic [2:0][DW-1:0]     rd;
  logic [2:0]             rbusy;

  // A write to register 0 is not a commit: it neither stores data nor clears busy.
  assign commit0     = bus.we0 && (bus.wa0 != '0);
  assign commit1     = bus.we1 && (bus.wa1 != '0);
  // Port 0 yields when the younger port writes the same register in the same cycle.
  assign commit0_eff = commit0 && !(commit1 && (bus.wa1 == bus.wa0));
  assign iss_set     = bus.iss_we && (bus.iss_addr != '0);

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;
  assign ra[2] = bus.ra3;

  // Storage update: committed writes, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (commit0_eff) regs[bus.wa0] <= bus.wd0;
      if (commit1)     regs[bus.wa1] <= bus.wd1;
    end
  end

  // Next busy vector: writes clear their target, then a new issue sets its target.
  // Applying the set last makes a same-cycle issue win over a retiring write.
  always_comb begin
    busy_nxt = busy;
    if (commit0) busy_nxt[bus.wa0] = 1'b0;
    if (commit1) busy_nxt[bus.wa1] = 1'b0;
    if (iss_set) busy_nxt[bus.iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector, so the count lands on the same edge as the bits.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
  end

  // Busy scoreboard and its count.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Read ports: stored value and busy flag, optionally overridden by same-cycle writes.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd[k]    = (ra[k] == '0) ? '0 : regs[ra[k]];
      rbusy[k] = busy[ra[k]];
`ifdef GRF_MULTIPORT_BYPASS_EN
      // Port 1 is evaluated last so it takes priority over port 0.
      if (commit0 && (bus.wa0 == ra[k])) begin
        rd[k] = bus.wd0;
        if (!(iss_set && (bus.iss_addr == ra[k]))) rbusy[k] = 1'b0;
      end
      if (commit1 && (bus.wa1 == ra[k])) begin
        rd[k] = bus.wd1;
        if (!(iss_set && (bus.iss_addr == ra[k]))) rbusy[k] = 1'b0;
      end
`endif
    end
  end

  assign bus.rd1      = rd[0];
  assign bus.rd2      = rd[1];
  assign bus.rd3      = rd[2];
  assign bus.rbusy1   = rbusy[0];
  assign bus.rbusy2   = rbusy[1];
  assign bus.rbusy3   = rbusy[2];
  assign bus.busy_cnt = cnt_q;

endmodule

// File: tb/tb_grf_multiport.sv
// tb_grf_multiport: directed scenarios plus a randomized run for grf_multiport.
// Each observation is seven values in fixed order: rd1, rd2, rd3, rbusy1, rbusy2, rbusy3, busy_cnt.
module tb_grf_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2**AW;

  logic clk;
  logic reset;

  grf_multiport_if #(.DW(DW), .AW(AW)) bus ();

  grf_multiport #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [DW-1:0] exp_q [$];
  int            vectors;
  int            miscompares;
  string         port_nm [7];

  // Reference model state
  logic [DW-1:0]    m_regs [DEPTH];
  logic [DEPTH-1:0] m_busy;
  int               m_cnt;

  function automatic logic [DW-1:0] obs_val(input int k);
    case (k)
      0:       return bus.rd1;
      1:       return bus.rd2;
      2:       return bus.rd3;
      3:       return DW'(bus.rbusy1);
      4:       return DW'(bus.rbusy2);
      5:       return DW'(bus.rbusy3);
      default: return DW'(bus.busy_cnt);
    endcase
  endfunction

  // Expected read data for address a given model state and the inputs currently driven.
  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = (a == 0) ? '0 : m_regs[a];
`ifdef GRF_MULTIPORT_BYPASS_EN
    if (a != 0) begin
      if (bus.we1 && bus.wa1 == a)      v = bus.wd1;
      else if (bus.we0 && bus.wa0 == a) v = bus.wd0;
    end
`endif
    return v;
  endfunction

  function automatic logic m_rbusy(input logic [AW-1:0] a);
    logic b;
    b = m_busy[a];
`ifdef GRF_MULTIPORT_BYPASS_EN
    if (a != 0 && ((bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a))
        && !(bus.iss_we && bus.iss_addr == a))
      b = 1'b0;
`endif
    return b;
  endfunction

  // Advance the model by one edge using the inputs being presented.
  task automatic model_apply();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (bus.we0 && bus.wa0 != 0) begin
        m_regs[bus.wa0] = bus.wd0;
        m_busy[bus.wa0] = 1'b0;
      end
      if (bus.we1 && bus.wa1 != 0) begin
        m_regs[bus.wa1] = bus.wd1;
        m_busy[bus.wa1] = 1'b0;
      end
      if (bus.iss_we && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
    end
    m_cnt = $countones(m_busy);
  endtask

  // Driver tasks
  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.wa0 = '0;   bus.wa1 = '0;
    bus.wd0 = '0;   bus.wd1 = '0;
    bus.iss_we = 1'b0; bus.iss_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    bus.ra1 = a1; bus.ra2 = a2; bus.ra3 = a3;
  endtask

  task automatic push7(input logic [DW-1:0] r1, input logic [DW-1:0] r2, input logic [DW-1:0] r3,
                       input logic b1, input logic b2, input logic b3, input int cnt);
    exp_q.push_back(r1); exp_q.push_back(r2); exp_q.push_back(r3);
    exp_q.push_back(DW'(b1)); exp_q.push_back(DW'(b2)); exp_q.push_back(DW'(b3));
    exp_q.push_back(DW'(cnt));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    set_ra(5'd5, 5'd31, 5'd0);
    push7(0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reset %s got %h want %h", port_nm[k], g, e);
      end
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    set_ra(5'd3, 5'd5, 5'd0);
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'hDEADBEEF;
`ifdef GRF_MULTIPORT_BYPASS_EN
    push7(32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
`else
    push7(0, 0, 0, 0, 0, 0, 0);
`endif
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bypass_same %s got %h want %h", port_nm[k], g, e);
      end
    end
    step();
    idle();
    push7(32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bypass_next %s got %h want %h", port_nm[k], g, e);
      end
    end
  endtask

  task automatic test_younger_wins();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    set_ra(5'd7, 5'd3, 5'd0);
    bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h11;
    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h22;
`ifdef GRF_MULTIPORT_BYPASS_EN
    push7(32'h22, 32'hDEADBEEF, 0, 0, 0, 0, 0);
`else
    push7(0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
`endif
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL younger_same %s got %h want %h", port_nm[k], g, e);
      end
    end
    step();
    idle();
    push7(32'h22, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL younger_next %s got %h want %h", port_nm[k], g, e);
      end
    end
  endtask

  task automatic test_reg0();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    set_ra(5'd0, 5'd0, 5'd7);
    bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hFFFFFFFF;
    bus.iss_we = 1'b1; bus.iss_addr = 5'd0;
    push7(0, 0, 32'h22, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reg0_same %s got %h want %h", port_nm[k], g, e);
      end
    end
    step();
    idle();
    push7(0, 0, 32'h22, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL reg0_next %s got %h want %h", port_nm[k], g, e);
      end
    end
  endtask

  task automatic test_busy();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    set_ra(5'd4, 5'd9, 5'd0);
    bus.iss_we = 1'b1; bus.iss_addr = 5'd4;
    step();
    bus.iss_addr = 5'd9;
    push7(0, 0, 0, 1, 0, 0, 1);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL busy_iss4 %s got %h want %h", port_nm[k], g, e);
      end
    end
    step();
    // Write 4 and reissue 4 in the same cycle: the new producer keeps it pending.
    bus.iss_addr = 5'd4;
    bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'h44;
`ifdef GRF_MULTIPORT_BYPASS_EN
    push7(32'h44, 0, 0, 1, 1, 0, 2);
`else
    push7(0, 0, 0, 1, 1, 0, 2);
`endif
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL busy_wr_iss %s got %h want %h", port_nm[k], g, e);
      end
    end
    step();
    idle();
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h99;
`ifdef GRF_MULTIPORT_BYPASS_EN
    push7(32'h44, 32'h99, 0, 1, 0, 0, 2);
`else
    push7(32'h44, 0, 0, 1, 1, 0, 2);
`endif
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL busy_wr9 %s got %h want %h", port_nm[k], g, e);
      end
    end
    step();
    idle();
    push7(32'h44, 32'h99, 0, 1, 0, 0, 1);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL busy_after %s got %h want %h", port_nm[k], g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    // Register 4 is still pending from the previous scenario.
    set_ra(5'd2, 5'd6, 5'd8);
    bus.iss_we = 1'b1;
    bus.iss_addr = 5'd2; step();
    bus.iss_addr = 5'd6; step();
    bus.iss_addr = 5'd8; step();
    idle();
    push7(0, 0, 0, 1, 1, 1, 4);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL mid_pending %s got %h want %h", port_nm[k], g, e);
      end
    end
    // Single reset cycle with a write and an issue that must be ignored.
    reset = 1'b1;
    bus.we0 = 1'b1; bus.wa0 = 5'd2; bus.wd0 = 32'h5555;
    bus.iss_we = 1'b1; bus.iss_addr = 5'd6;
    step();
    reset = 1'b0;
    idle();
    push7(0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL mid_reset %s got %h want %h", port_nm[k], g, e);
      end
    end
    set_ra(5'd3, 5'd7, 5'd4);
    push7(0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int k = 0; k < 7; k++) begin
      e = exp_q.pop_front(); g = obs_val(k); vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL mid_reset_data %s got %h want %h", port_nm[k], g, e);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e;
    logic [DW-1:0] g;
    logic [AW-1:0] a [3];
    do_reset();
    for (int c = 0; c < 300; c++) begin
      // Small address pool for frequent collisions.
      bus.we0 = 1'($urandom_range(0, 1));
      bus.we1 = 1'($urandom_range(0, 1));
      bus.wa0 = AW'($urandom_range(0, 7));
      bus.wa1 = AW'($urandom_range(0, 7));
      bus.wd0 = $urandom;
      bus.wd1 = $urandom;
      bus.iss_we = 1'($urandom_range(0, 1));
      bus.iss_addr = AW'($urandom_range(0, 7));
      for (int j = 0; j < 3; j++) a[j] = AW'($urandom_range(0, 8));
      set_ra(a[0], a[1], a[2]);
      push7(m_rd(a[0]), m_rd(a[1]), m_rd(a[2]),
            m_rbusy(a[0]), m_rbusy(a[1]), m_rbusy(a[2]), m_cnt);
      #1;
      for (int k = 0; k < 7; k++) begin
        e = exp_q.pop_front(); g = obs_val(k); vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL random c%0d %s got %h want %h", c, port_nm[k], g, e);
        end
      end
      step();
    end
    idle();
  endtask

  // Sequence and final report
  initial begin
    port_nm = '{"rd1", "rd2", "rd3", "rbusy1", "rbusy2", "rbusy3", "busy_cnt"};
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_busy = '0;
    m_cnt = 0;
    set_ra('0, '0, '0);
    do_reset();
    test_reset();
    test_bypass();
    test_younger_wins();
    test_reg0();
    test_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
